// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the five-stage core: register and word widths,
// the hazard unit state encoding, and the load-use dependence check.
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } hazard_state_t;

    localparam word_t STAT_MAX = 32'hFFFF_FFFF;

    // Load in EX feeding a source of the ID instruction; register 0 never stalls.
    function automatic logic load_use_dep(
        input logic     ex_dre,
        input regbits_t ex_dst,
        input regbits_t id_rs,
        input regbits_t id_rt,
        input logic     id_uses_rt
    );
        return ex_dre && (ex_dst != '0) &&
               ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_counters.sv
// Saturating stall / flush event counters for the hazard unit.
// Only instantiated when HAZARD_STATS_EN is defined.
module hazard_counters
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  stall_inc,
    input  logic  flush_inc,
    output word_t stall_cnt,
    output word_t flush_cnt
);

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != STAT_MAX))
                stall_cnt <= stall_cnt + 32'd1;
            if (flush_inc && (flush_cnt != STAT_MAX))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: write enables and flushes for PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB. Optional statistics counters under HAZARD_STATS_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | pipeline active; controls follow the hazard priority rules
// HALTED | HALT reached MEM; all registers frozen until RST
//
// iheld: an instruction arrived while IF/ID was frozen and is still on the
// fetch bus side, so the next advance can proceed without a fresh ihit.
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     dmemreq,
    input  regbits_t idrs,
    input  regbits_t idrt,
    input  logic     idUsesRt,
    input  logic     exDRE,
    input  regbits_t exdst,
    input  logic     brtaken,
    input  logic     jmp,
    input  logic     memHALT,
    output logic     pcW,
    output logic     ifidW,
    output logic     ifidRST,
    output logic     idW,
    output logic     idRST,
    output logic     exmemW,
    output logic     memwbW,
    output logic     memwbRST,
    output logic     halt
`ifdef HAZARD_STATS_EN
    ,
    output word_t    stall_cnt,
    output word_t    flush_cnt
`endif
);

    hazard_state_t state, next_state;
    logic          iheld, next_iheld;
    logic          dstall, redirect, lduse, fetch_ok;

    assign dstall   = dmemreq && !dhit;
    assign redirect = brtaken || jmp;
    assign lduse    = load_use_dep(exDRE, exdst, idrs, idrt, idUsesRt);
    assign fetch_ok = ihit || iheld;
    assign halt     = (state == HALTED);

    // State and held-fetch flag registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
            iheld <= 1'b0;
        end else begin
            state <= next_state;
            iheld <= next_iheld;
        end
    end

    // Next state and held-fetch flag, following the hazard priority order.
    always_comb begin
        next_state = state;
        next_iheld = iheld;
        if (state == RUN) begin
            if (memHALT) begin
                next_state = HALTED;
                next_iheld = 1'b0;
            end else if (dstall) begin
                if (ihit) next_iheld = 1'b1;
            end else if (redirect) begin
                next_iheld = 1'b0;
            end else if (lduse) begin
                if (ihit) next_iheld = 1'b1;
            end else if (fetch_ok) begin
                next_iheld = 1'b0;
            end
        end
    end

    // Mealy register controls; everything is held off while reset is asserted.
    always_comb begin
        pcW      = 1'b0;
        ifidW    = 1'b0;
        ifidRST  = 1'b0;
        idW      = 1'b0;
        idRST    = 1'b0;
        exmemW   = 1'b0;
        memwbW   = 1'b0;
        memwbRST = 1'b0;
        if (!RST && (state == RUN)) begin
            pcW    = 1'b1;
            ifidW  = 1'b1;
            idW    = 1'b1;
            exmemW = 1'b1;
            memwbW = 1'b1;
            if (memHALT) begin
                // HALT carries no memory access, so it overrides a data stall.
            end else if (dstall) begin
                pcW      = 1'b0;
                ifidW    = 1'b0;
                idW      = 1'b0;
                exmemW   = 1'b0;
                memwbRST = 1'b1;
            end else if (redirect) begin
                ifidRST = 1'b1;
                idRST   = 1'b1;
            end else if (lduse) begin
                pcW   = 1'b0;
                ifidW = 1'b0;
                idRST = 1'b1;
            end else if (!fetch_ok) begin
                pcW     = 1'b0;
                ifidRST = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic stall_inc, flush_inc;

    assign stall_inc = !RST && (state == RUN) && !pcW;
    assign flush_inc = !RST && (state == RUN) && !memHALT && !dstall && redirect;

    hazard_counters u_counters (
        .CLK       (CLK),
        .RST       (RST),
        .stall_inc (stall_inc),
        .flush_inc (flush_inc),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit. Each stimulus cycle pushes the
// hand-computed control vector; a negedge monitor pops and compares.
// Vector bit order: pcW ifidW ifidRST idW idRST exmemW memwbW memwbRST halt.
module tb_hazard_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ihit = 1'b0, dhit = 1'b0, dmemreq = 1'b0;
    logic [4:0] idrs = '0, idrt = '0, exdst = '0;
    logic       idUsesRt = 1'b0, exDRE = 1'b0;
    logic       brtaken = 1'b0, jmp = 1'b0, memHALT = 1'b0;
    logic       pcW, ifidW, ifidRST, idW, idRST, exmemW, memwbW, memwbRST, halt;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [31:0] esc = '0, efc = '0;
`endif

    localparam logic [8:0] V_ZERO  = 9'b000000000;
    localparam logic [8:0] V_ALL   = 9'b110101100;
    localparam logic [8:0] V_FWAIT = 9'b011101100;
    localparam logic [8:0] V_LU    = 9'b000111100;
    localparam logic [8:0] V_DST   = 9'b000000110;
    localparam logic [8:0] V_REDIR = 9'b111111100;
    localparam logic [8:0] V_HALT  = 9'b000000001;

    hazard_unit dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmemreq(dmemreq),
        .idrs(idrs), .idrt(idrt), .idUsesRt(idUsesRt), .exDRE(exDRE),
        .exdst(exdst), .brtaken(brtaken), .jmp(jmp), .memHALT(memHALT),
        .pcW(pcW), .ifidW(ifidW), .ifidRST(ifidRST), .idW(idW), .idRST(idRST),
        .exmemW(exmemW), .memwbW(memwbW), .memwbRST(memwbRST), .halt(halt)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    logic [8:0]  exp_q[$];
    string       name_q[$];
`ifdef HAZARD_STATS_EN
    logic [31:0] sc_q[$];
    logic [31:0] fc_q[$];
`endif
    int compared = 0;
    int mismatched = 0;

    // Monitor: every cycle with a pending expectation is compared.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [8:0] e, a;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {pcW, ifidW, ifidRST, idW, idRST, exmemW, memwbW, memwbRST, halt};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL %s: ctl got %b expected %b", n, a, e);
            end
`ifdef HAZARD_STATS_EN
            begin
                logic [31:0] es, ef;
                es = sc_q.pop_front();
                ef = fc_q.pop_front();
                compared += 2;
                if (stall_cnt !== es) begin
                    mismatched++;
                    $display("FAIL %s: stall_cnt got %0d expected %0d", n, stall_cnt, es);
                end
                if (flush_cnt !== ef) begin
                    mismatched++;
                    $display("FAIL %s: flush_cnt got %0d expected %0d", n, flush_cnt, ef);
                end
            end
`endif
        end
    end

    // One cycle: drive inputs just after the edge, queue the expected controls.
    task automatic step(input string nm, input logic r, input logic ih, input logic dh,
                        input logic dm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic exl, input logic [4:0] dst,
                        input logic br, input logic jp, input logic mh,
                        input logic [8:0] e);
        @(posedge CLK);
        #1;
        RST = r; ihit = ih; dhit = dh; dmemreq = dm; idrs = rs; idrt = rt;
        idUsesRt = urt; exDRE = exl; exdst = dst; brtaken = br; jmp = jp; memHALT = mh;
`ifdef HAZARD_STATS_EN
        if (r) begin
            esc = '0;
            efc = '0;
        end
        sc_q.push_back(esc);
        fc_q.push_back(efc);
        if (!r) begin
            if (!e[8] && !e[0] && esc != 32'hFFFF_FFFF) esc = esc + 32'd1;
            if (e == V_REDIR && efc != 32'hFFFF_FFFF) efc = efc + 32'd1;
        end
`endif
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        //    name          rst ih dh dm rs  rt  urt ld dst br jp mh expected
        step("reset0",      1, 1, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0, V_ZERO);
        step("reset1",      1, 1, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0, V_ZERO);
        step("run",         0, 1, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0, V_ALL);
        step("fetch_wait",  0, 0, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0, V_FWAIT);
        step("lduse_rs",    0, 1, 0, 0, 5,  0,  0, 1, 5,  0, 0, 0, V_LU);
        step("lduse_after", 0, 0, 0, 0, 5,  0,  0, 0, 5,  0, 0, 0, V_ALL);
        step("lduse_r0",    0, 1, 0, 0, 0,  0,  1, 1, 0,  0, 0, 0, V_ALL);
        step("rt_unused",   0, 1, 0, 0, 3,  7,  0, 1, 7,  0, 0, 0, V_ALL);
        step("lduse_rt",    0, 1, 0, 0, 3,  7,  1, 1, 7,  0, 0, 0, V_LU);
        step("rt_after",    0, 1, 0, 0, 3,  7,  1, 0, 7,  0, 0, 0, V_ALL);
        step("dstall_c1",   0, 0, 0, 1, 0,  0,  0, 0, 0,  0, 0, 0, V_DST);
        step("dstall_c2",   0, 1, 0, 1, 0,  0,  0, 0, 0,  0, 0, 0, V_DST);
        step("dstall_c3",   0, 0, 0, 1, 0,  0,  0, 0, 0,  0, 0, 0, V_DST);
        step("dhit_held",   0, 0, 1, 1, 0,  0,  0, 0, 0,  0, 0, 0, V_ALL);
        step("held_used",   0, 0, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0, V_FWAIT);
        step("branch",      0, 1, 0, 0, 0,  0,  0, 0, 0,  1, 0, 0, V_REDIR);
        step("jump",        0, 0, 0, 0, 0,  0,  0, 0, 0,  0, 1, 0, V_REDIR);
        step("br_vs_stall", 0, 1, 0, 1, 0,  0,  0, 0, 0,  1, 0, 0, V_DST);
        step("br_after_hit",0, 0, 1, 1, 0,  0,  0, 0, 0,  1, 0, 0, V_REDIR);
        step("br_clr_held", 0, 0, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0, V_FWAIT);
        step("br_vs_lduse", 0, 1, 0, 0, 9,  0,  0, 1, 9,  1, 0, 0, V_REDIR);
        step("rst_stall",   0, 1, 0, 1, 0,  0,  0, 0, 0,  0, 0, 0, V_DST);
        step("rst_mid",     1, 0, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0, V_ZERO);
        step("rst_drop",    0, 0, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0, V_FWAIT);
        step("halt_vs_ds",  0, 1, 0, 1, 0,  0,  0, 0, 0,  0, 0, 1, V_ALL);
        step("halted_br",   0, 1, 0, 0, 0,  0,  0, 0, 0,  1, 0, 0, V_HALT);
        step("halted_ld",   0, 1, 0, 1, 4,  0,  0, 1, 4,  0, 0, 0, V_HALT);
        step("halted_idle", 0, 0, 0, 0, 0,  0,  0, 0, 0,  0, 1, 1, V_HALT);
        step("halt_rst",    1, 1, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0, V_ZERO);
        step("after_halt",  0, 1, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0, V_ALL);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
